// File: rtl/uart_cpld_responder_if.sv
// rtl/uart_cpld_responder_if.sv - CPU parallel UART port bundle
//
// Purpose: groups the CPU-side parallel UART signals (strobes, bus byte,
// status flags) so the responder and its host connect through one port.
// Signals:
//   rdn, wrn    active-low read/write strobes from the CPU
//   data_in     bus byte presented with wrn low
//   data_out    receive buffer byte
//   data_oe     bus drive enable (high while rdn low)
//   dataready   receive buffer holds an unread byte
//   tbre        transmit holding register empty
//   tsre        transmit shifter empty (line idle)
// Modports: master = CPU side, slave = responder side.

interface uart_cpld_responder_if;
    logic       rdn;
    logic       wrn;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       dataready;
    logic       tbre;
    logic       tsre;

    modport master (
        output rdn, wrn, data_in,
        input  data_out, data_oe, dataready, tbre, tsre
    );

    modport slave (
        input  rdn, wrn, data_in,
        output data_out, data_oe, dataready, tbre, tsre
    );
endinterface

// File: rtl/uart_cpld_responder.sv
// rtl/uart_cpld_responder.sv - parallel-port UART responder with 8N1 TX/RX
//
// Purpose: turns CPU byte writes into 8N1 frames on txd and deserialises
// rxd into a one-byte receive buffer readable over the parallel port.
// Ports:
//   clk         system clock, all state on posedge
//   rst         asynchronous active-high reset
//   bus         parallel UART port (slave side)
//   txd         serial out, idle high
//   rxd         serial in, asynchronous to clk
//   rx_overrun  1-cycle pulse when an unread byte is overwritten
//   frame_err   1-cycle pulse when a stop bit samples low (byte dropped)

module uart_cpld_responder #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_cpld_responder_if.slave        bus,
    output logic                        txd,
    input  logic                        rxd,
    output logic                        rx_overrun,
    output logic                        frame_err
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] C_BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HALF_END = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Strobe edge detection: an access fires when the previous sample was
    // high and the current input is low, so a held strobe fires once.
    // ------------------------------------------------------------------
    logic r_rdn_q;
    logic r_wrn_q;
    logic w_rd_fire;
    logic w_wr_fire;

    assign w_rd_fire = r_rdn_q & ~bus.rdn;
    assign w_wr_fire = r_wrn_q & ~bus.wrn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdn_q <= 1'b1;
            r_wrn_q <= 1'b1;
        end else begin
            r_rdn_q <= bus.rdn;
            r_wrn_q <= bus.wrn;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t        r_tx_state;
    state_t        w_tx_state_n;
    logic [CW-1:0] r_tx_cnt;
    logic [CW-1:0] w_tx_cnt_n;
    logic [2:0]    r_tx_bit;
    logic [2:0]    w_tx_bit_n;
    logic [7:0]    r_tx_shift;
    logic [7:0]    w_tx_shift_n;
    logic [7:0]    r_hold;
    logic          r_tbre;
    logic          r_tsre;
    logic          r_txd;
    logic          w_tx_load;
    logic          w_tx_done;
    logic          w_txd_n;
    logic          w_hold_wr;

    // Writes are only taken while the holding register is free.
    assign w_hold_wr = w_wr_fire & r_tbre;

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_load    = 1'b0;
        w_tx_done    = 1'b0;
        w_txd_n      = 1'b1;

        case (r_tx_state)
            ST_IDLE: begin
                if (!r_tbre) begin
                    w_tx_load    = 1'b1;
                    w_tx_shift_n = r_hold;
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (r_tx_cnt == C_BIT_END) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = 3'd0;
                    w_tx_state_n = ST_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == C_BIT_END) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = ST_STOP;
                    end else begin
                        w_tx_bit_n = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == C_BIT_END) begin
                    w_tx_cnt_n = '0;
                    // A byte already waiting goes straight out with no idle gap.
                    if (!r_tbre) begin
                        w_tx_load    = 1'b1;
                        w_tx_shift_n = r_hold;
                        w_tx_state_n = ST_START;
                    end else begin
                        w_tx_done    = 1'b1;
                        w_tx_state_n = ST_IDLE;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_state_n = ST_IDLE;
            end
        endcase

        // txd is registered from the next state so it never glitches.
        case (w_tx_state_n)
            ST_START: w_txd_n = 1'b0;
            ST_DATA:  w_txd_n = w_tx_shift_n[0];
            default:  w_txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_hold     <= 8'h00;
            r_tbre     <= 1'b1;
            r_tsre     <= 1'b1;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_txd      <= w_txd_n;
            if (w_hold_wr) begin
                r_hold <= bus.data_in;
            end
            // Load only happens with tbre low and a write only with tbre
            // high, so these two never collide.
            if (w_tx_load) begin
                r_tbre <= 1'b1;
            end else if (w_hold_wr) begin
                r_tbre <= 1'b0;
            end
            if (w_tx_load) begin
                r_tsre <= 1'b0;
            end else if (w_tx_done) begin
                r_tsre <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          r_rx_s1;
    logic          r_rx_s2;
    state_t        r_rx_state;
    state_t        w_rx_state_n;
    logic [CW-1:0] r_rx_cnt;
    logic [CW-1:0] w_rx_cnt_n;
    logic [2:0]    r_rx_bit;
    logic [2:0]    w_rx_bit_n;
    logic [7:0]    r_rx_shift;
    logic [7:0]    w_rx_shift_n;
    logic          w_rx_commit;
    logic          w_rx_ferr;
    logic [7:0]    r_data_out;
    logic          r_dataready;
    logic          r_rx_overrun;
    logic          r_frame_err;

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_commit  = 1'b0;
        w_rx_ferr    = 1'b0;

        case (r_rx_state)
            ST_IDLE: begin
                if (!r_rx_s2) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = ST_START;
                end
            end
            ST_START: begin
                // Re-check at mid start bit; short low pulses are ignored.
                if (r_rx_cnt == C_HALF_END) begin
                    w_rx_cnt_n = '0;
                    w_rx_bit_n = 3'd0;
                    w_rx_state_n = r_rx_s2 ? ST_IDLE : ST_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == C_BIT_END) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = ST_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == C_BIT_END) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = ST_IDLE;
                    w_rx_commit  = r_rx_s2;
                    w_rx_ferr    = ~r_rx_s2;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            default: begin
                w_rx_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_state   <= ST_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_data_out   <= 8'h00;
            r_dataready  <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_s1      <= rxd;
            r_rx_s2      <= r_rx_s1;
            r_rx_state   <= w_rx_state_n;
            r_rx_cnt     <= w_rx_cnt_n;
            r_rx_bit     <= w_rx_bit_n;
            r_rx_shift   <= w_rx_shift_n;
            r_frame_err  <= w_rx_ferr;
            // A read in the completing cycle consumes the old byte, so the
            // new one is not counted as an overrun.
            r_rx_overrun <= w_rx_commit & r_dataready & ~w_rd_fire;
            if (w_rx_commit) begin
                r_data_out  <= r_rx_shift;
                r_dataready <= 1'b1;
            end else if (w_rd_fire) begin
                r_dataready <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.data_out  = r_data_out;
    assign bus.data_oe   = ~bus.rdn;
    assign bus.dataready = r_dataready;
    assign bus.tbre      = r_tbre;
    assign bus.tsre      = r_tsre;
    assign txd           = r_txd;
    assign rx_overrun    = r_rx_overrun;
    assign frame_err     = r_frame_err;
endmodule
